// File: rtl/decoder_3to8_sync.sv
`default_nettype none
// ============================================================================
// Module   : decoder_3to8_sync
// Brief    : Registered 3-to-8 one-hot decoder with enable and selectable
//            output polarity; valid is a registered copy of the enable.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_3to8_sync #(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] in,
    output logic [7:0] out,
    output logic       valid
);

    localparam logic [7:0] c_INACTIVE = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [7:0] w_onehot;
    logic [7:0] w_out_next;
    logic [7:0] r_out;
    logic       r_valid;

    generate
        for (genvar k = 0; k < 8; k++) begin : g_bit
            assign w_onehot[k] = en && (in == 3'(k));
        end
    endgenerate

    // Polarity is applied before the register so the flops drive the pins.
    assign w_out_next = OUT_ACTIVE_LOW ? ~w_onehot : w_onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= c_INACTIVE;
            r_valid <= 1'b0;
        end else begin
            r_out   <= w_out_next;
            r_valid <= en;
        end
    end

    assign out   = r_out;
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_decoder_3to8_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_3to8_sync
// Brief    : Self-checking bench for decoder_3to8_sync, both polarities.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_3to8_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] in;
    logic [7:0] out_hi;
    logic [7:0] out_lo;
    logic       valid_hi;
    logic       valid_lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_3to8_sync #(.OUT_ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .in    (in),
        .out   (out_hi),
        .valid (valid_hi)
    );

    decoder_3to8_sync #(.OUT_ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .in    (in),
        .out   (out_lo),
        .valid (valid_lo)
    );

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then check the outputs produced by that edge.
    task automatic step(input string tag, input logic r, input logic e, input logic [2:0] sel);
        logic [7:0] exp_hi;
        logic       exp_v;
        @(negedge clk);
        rst = r;
        en  = e;
        in  = sel;
        exp_v  = !r && e;
        exp_hi = exp_v ? (8'd1 << sel) : 8'd0;
        @(posedge clk);
        #1;
        check8({tag, "_out_hi"}, out_hi, exp_hi);
        check8({tag, "_out_lo"}, out_lo, ~exp_hi);
        check1({tag, "_valid_hi"}, valid_hi, exp_v);
        check1({tag, "_valid_lo"}, valid_lo, exp_v);
        if (exp_v) check1({tag, "_onehot"}, $countones(out_hi) == 1, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        in  = 3'd5;

        step("reset0", 1'b1, 1'b1, 3'd5);
        step("reset1", 1'b1, 1'b1, 3'd5);
        step("release", 1'b0, 1'b1, 3'd5);

        for (int i = 0; i < 8; i++) step("sweep", 1'b0, 1'b1, 3'(i));
        step("wrap0", 1'b0, 1'b1, 3'd0);
        step("wrap1", 1'b0, 1'b1, 3'd1);

        step("en_on", 1'b0, 1'b1, 3'd3);
        step("en_off", 1'b0, 1'b0, 3'd3);
        step("en_on2", 1'b0, 1'b1, 3'd3);
        step("en_off_any", 1'b0, 1'b0, 3'd7);

        for (int i = 0; i < 4; i++) step("pre_rst", 1'b0, 1'b1, 3'(i));
        step("mid_rst", 1'b1, 1'b1, 3'd4);
        step("resume", 1'b0, 1'b1, 3'd6);

        step("rst_no_en", 1'b1, 1'b0, 3'd2);
        step("lo_sel2", 1'b0, 1'b1, 3'd2);
        step("lo_dis", 1'b0, 1'b0, 3'd2);

        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
